decode_stage: RTL

//  Registered RV32I decode stage between fetch/IROM and execute, with one output register stage and valid/ready on both sides.

---
 rtl/decode_stage.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes one instruction per accepted transfer into a
// control/immediate bundle held in a single output register with valid/ready on both sides.
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int EN_MEXT   = 0,
    parameter int EN_HAZARD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            setup,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_alu_op,
    output logic [1:0]      out_br_type,
    output logic            out_reg_write_en,
    output logic            out_ram_write_en,
    output logic            out_ram_read_en,
    output logic            out_ram_sign,
    output logic [3:0]      out_ram_type,
    output logic            out_mux_op1_sel,
    output logic            out_mux_op2_sel,
    output logic            out_mux_br_sel,
    output logic [1:0]      out_mux_writeback,
    output logic            out_mext,
    output logic [2:0]      out_muldiv_op,
    output logic            out_illegal,
    output logic            hazard_stall,
    output logic            irom_write_en,
    output logic            irom_read_en,
    output logic            pc_write_first_addr
);
    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits on ready, and a held bundle stays stable until it transfers.

    localparam logic [4:0] ALU_NONE = 5'd0,  ALU_ADD  = 5'd1,  ALU_SUB  = 5'd2,  ALU_SLL = 5'd3;
    localparam logic [4:0] ALU_SLT  = 5'd4,  ALU_SLTU = 5'd5,  ALU_XOR  = 5'd6,  ALU_SRL = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8,  ALU_OR   = 5'd9,  ALU_AND  = 5'd10, ALU_BEQ = 5'd11;
    localparam logic [4:0] ALU_BNE  = 5'd12, ALU_BLT  = 5'd13, ALU_BGE  = 5'd14, ALU_BLTU = 5'd15;
    localparam logic [4:0] ALU_BGEU = 5'd16, ALU_LUI  = 5'd17;
    localparam logic [1:0] BR_NONE = 2'd0, BR_JAL = 2'd1, BR_JALR = 2'd2, BR_BR = 2'd3;
    localparam logic [1:0] WB_NO_DATA = 2'd0, WB_ALU_OUT = 2'd1, WB_RAM = 2'd2, WB_PC4 = 2'd3;

    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011, OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011, OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      alu_op;
        logic [1:0]      br_type;
        logic            reg_write_en;
        logic            ram_write_en;
        logic            ram_read_en;
        logic            ram_sign;
        logic [3:0]      ram_type;
        logic            op1_sel;
        logic            op2_sel;
        logic            br_sel;
        logic [1:0]      writeback;
        logic            mext;
        logic [2:0]      muldiv_op;
        logic            illegal;
    } bundle_t;

    function automatic logic [4:0] alu_fn3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_fn3 = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_fn3 = ALU_SLL;
            3'd2:    alu_fn3 = ALU_SLT;
            3'd3:    alu_fn3 = ALU_SLTU;
            3'd4:    alu_fn3 = ALU_XOR;
            3'd5:    alu_fn3 = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_fn3 = ALU_OR;
            default: alu_fn3 = ALU_AND;
        endcase
    endfunction

    function automatic logic [4:0] br_fn3(input logic [2:0] f3);
        case (f3)
            3'd0:    br_fn3 = ALU_BEQ;
            3'd1:    br_fn3 = ALU_BNE;
            3'd4:    br_fn3 = ALU_BLT;
            3'd5:    br_fn3 = ALU_BGE;
            3'd6:    br_fn3 = ALU_BLTU;
            3'd7:    br_fn3 = ALU_BGEU;
            default: br_fn3 = ALU_NONE;
        endcase
    endfunction

    // Byte-lane mask for the access size in FN3[1:0].
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    logic [6:0]      opcode, fn7;
    logic [2:0]      fn3;
    logic [4:0]      rd_f, rs1_f, rs2_f;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    bundle_t         d, q;
    logic            legal, uses_rs1, uses_rs2, hazard, valid_q;

    assign opcode = instr_in[6:0];
    assign fn3    = instr_in[14:12];
    assign fn7    = instr_in[31:25];
    assign rd_f   = instr_in[11:7];
    assign rs1_f  = instr_in[19:15];
    assign rs2_f  = instr_in[24:20];
    assign imm_i  = XLEN'($signed(instr_in[31:20]));
    assign imm_s  = XLEN'($signed({instr_in[31:25], instr_in[11:7]}));
    assign imm_b  = XLEN'($signed({instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({instr_in[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0}));

    always_comb begin
        d        = '0;
        d.pc     = pc_in;
        legal    = 1'b1;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_OP: begin
                d.rd = rd_f; d.rs1 = rs1_f; d.rs2 = rs2_f;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                d.op2_sel = 1'b1; d.reg_write_en = 1'b1; d.writeback = WB_ALU_OUT;
                if (fn7 == 7'b0000000 || (fn7 == 7'b0100000 && (fn3 == 3'd0 || fn3 == 3'd5)))
                    d.alu_op = alu_fn3(fn3, fn7[5]);
                else if (fn7 == 7'b0000001 && EN_MEXT != 0) begin
                    d.mext = 1'b1; d.muldiv_op = fn3;
                end else
                    legal = 1'b0;
            end
            OPC_IMM: begin
                d.rd = rd_f; d.rs1 = rs1_f; uses_rs1 = 1'b1;
                d.reg_write_en = 1'b1; d.writeback = WB_ALU_OUT;
                d.alu_op = alu_fn3(fn3, fn3 == 3'd5 && fn7[5]);
                // Shifts carry only the shamt; the upper field selects SRAI or is reserved.
                if (fn3 == 3'd1 || fn3 == 3'd5) begin
                    d.imm = XLEN'(instr_in[24:20]);
                    legal = (fn7 == 7'b0000000) || (fn3 == 3'd5 && fn7 == 7'b0100000);
                end else
                    d.imm = imm_i;
            end
            OPC_LOAD: begin
                d.rd = rd_f; d.rs1 = rs1_f; uses_rs1 = 1'b1; d.imm = imm_i;
                d.alu_op = ALU_ADD; d.ram_read_en = 1'b1; d.reg_write_en = 1'b1;
                d.writeback = WB_RAM; d.ram_sign = ~fn3[2]; d.ram_type = size_mask(fn3[1:0]);
                legal = (fn3 != 3'd3) && (fn3 < 3'd6);
            end
            OPC_STORE: begin
                d.rs1 = rs1_f; d.rs2 = rs2_f; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                d.imm = imm_s; d.alu_op = ALU_ADD; d.ram_write_en = 1'b1;
                d.ram_sign = 1'b1; d.ram_type = size_mask(fn3[1:0]); d.writeback = WB_NO_DATA;
                legal = (fn3 < 3'd3);
            end
            OPC_BRANCH: begin
                d.rs1 = rs1_f; d.rs2 = rs2_f; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                d.imm = imm_b; d.alu_op = br_fn3(fn3); d.br_type = BR_BR; d.op2_sel = 1'b1;
                legal = (fn3 != 3'd2) && (fn3 != 3'd3);
            end
            OPC_JAL: begin
                d.rd = rd_f; d.imm = imm_j; d.br_type = BR_JAL;
                d.reg_write_en = 1'b1; d.writeback = WB_PC4;
            end
            OPC_JALR: begin
                d.rd = rd_f; d.rs1 = rs1_f; uses_rs1 = 1'b1; d.imm = imm_i;
                d.br_type = BR_JALR; d.br_sel = 1'b1; d.reg_write_en = 1'b1; d.writeback = WB_PC4;
                legal = (fn3 == 3'd0);
            end
            OPC_LUI: begin
                d.rd = rd_f; d.imm = imm_u; d.alu_op = ALU_LUI;
                d.reg_write_en = 1'b1; d.writeback = WB_ALU_OUT;
            end
            OPC_AUIPC: begin
                d.rd = rd_f; d.imm = imm_u; d.alu_op = ALU_ADD; d.op1_sel = 1'b1;
                d.reg_write_en = 1'b1; d.writeback = WB_ALU_OUT;
            end
            default: legal = 1'b0;
        endcase
        // Illegal encodings travel as a flagged NOP so execute can trap on the PC.
        if (!legal) begin
            d         = '0;
            d.pc      = pc_in;
            d.illegal = 1'b1;
            uses_rs1  = 1'b0;
            uses_rs2  = 1'b0;
        end
    end

    assign hazard = (EN_HAZARD != 0) && valid_q && q.ram_read_en && (q.rd != 5'd0) &&
                    ((uses_rs1 && rs1_f == q.rd) || (uses_rs2 && rs2_f == q.rd));
    assign hazard_stall = rst_n & in_valid & hazard;
    assign in_ready     = rst_n & ~setup & ~flush & ~hazard & (~valid_q | out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            q       <= '0;
        end else if (flush || setup) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            q       <= d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid           = valid_q;
    assign out_pc              = q.pc;
    assign out_imm             = q.imm;
    assign out_rd              = q.rd;
    assign out_rs1             = q.rs1;
    assign out_rs2             = q.rs2;
    assign out_alu_op          = q.alu_op;
    assign out_br_type         = q.br_type;
    assign out_reg_write_en    = q.reg_write_en;
    assign out_ram_write_en    = q.ram_write_en;
    assign out_ram_read_en     = q.ram_read_en;
    assign out_ram_sign        = q.ram_sign;
    assign out_ram_type        = q.ram_type;
    assign out_mux_op1_sel     = q.op1_sel;
    assign out_mux_op2_sel     = q.op2_sel;
    assign out_mux_br_sel      = q.br_sel;
    assign out_mux_writeback   = q.writeback;
    assign out_mext            = q.mext;
    assign out_muldiv_op       = q.muldiv_op;
    assign out_illegal         = q.illegal;
    assign irom_write_en       = setup;
    assign irom_read_en        = ~setup;
    assign pc_write_first_addr = setup;
endmodule
